mem_dump_reader: RTL and testbench
==================================

// Module: mem_dump_reader
// PURPOSE
// Reader side of the data-memory debug bus. On request it walks every word of the
// MIPS data memory exposed on the flat debug bus and streams it, big-endian byte by
// byte, to the debug UART transmitter over a valid/ready byte interface.
// Sits between the mem stage debug output and the UART TX in the debug unit.
// PARAMETERS
// IO_BUS_SIZE    32  data word width in bits; must be a multiple of BYTE_SIZE
// MEM_ADDR_SIZE  5   data-memory address width; 2**MEM_ADDR_SIZE words are dumped
// BYTE_SIZE      8   width of one transmitted symbol
// PORTS
// i_clk        in   1                             single clock, rising edge
// i_reset      in   1                             asynchronous, active-low reset
// i_start      in   1                             dump request, sampled only in IDLE
// i_flush      in   1                             synchronous abort; returns to IDLE
// i_bus_debug  in   2**MEM_ADDR_SIZE*IO_BUS_SIZE  flat memory image, word k at [k*IO_BUS_SIZE +: IO_BUS_SIZE]
// i_tx_ready   in   1                             UART TX can accept a byte
// o_tx_data    out  BYTE_SIZE                     byte to transmit
// o_tx_valid   out  1                             o_tx_data is valid
// o_busy       out  1                             dump in progress (LOAD or SEND)
// o_done       out  1                             one-cycle pulse after the last byte is accepted
// o_addr       out  MEM_ADDR_SIZE                 word index currently being sent
// BEHAVIOUR
// - Reset (i_reset=0, any time): state=IDLE; o_tx_data=0, o_tx_valid=0, o_busy=0,
//   o_done=0, o_addr=0, byte counter=0, shift register=0. Takes effect immediately.
// - FSM states: IDLE, LOAD, SEND, DONE.
//   IDLE: i_start=1 -> LOAD with o_addr=0. Otherwise stay.
//   LOAD: latch word o_addr from i_bus_debug into the shift register, byte_cnt=0 -> SEND.
//   SEND: o_tx_valid=1, o_tx_data=shift[IO_BUS_SIZE-1 -: BYTE_SIZE] (MSB byte first).
//     Handshake = o_tx_valid & i_tx_ready on a rising edge.
//     On handshake with byte_cnt<BYTES_PER_WORD-1: shift left BYTE_SIZE, byte_cnt+1.
//     On handshake with the last byte: if o_addr==2**MEM_ADDR_SIZE-1 -> DONE,
//     else o_addr+1 -> LOAD.
//     No handshake: hold o_tx_data and o_tx_valid unchanged.
//   DONE: o_done=1 for exactly one cycle, o_tx_valid=0 -> IDLE; o_addr returns to 0.
// - Latency: i_start high at edge N -> LOAD after N, first byte valid after edge N+1.
//   Each word costs 1 LOAD cycle plus BYTES_PER_WORD accepted handshakes.
// - o_tx_valid is 0 in IDLE, LOAD and DONE. o_busy=1 in LOAD and SEND only.
// - i_start while busy or in DONE is ignored; no re-trigger or queuing.
// - i_flush=1 (priority over i_start and handshake): next state IDLE, o_tx_valid=0,
//   o_addr=0, byte_cnt=0, no o_done pulse; any pending byte is dropped.
// - i_bus_debug is sampled only in LOAD; changes during SEND do not affect the current word.
// - o_addr increments modulo 2**MEM_ADDR_SIZE; it never wraps in SEND because the last address exits to DONE.
// STRUCTURE
// - Shared mips constants header: BYTES_PER_WORD = IO_BUS_SIZE/BYTE_SIZE, the FSM state
//   encodings (2 bits), and the byte-counter width clog2(BYTES_PER_WORD).
// - One natural sub-module, word_serializer: load/shift register plus byte counter, with
//   i_load, i_shift, o_byte, o_last. The FSM and address counter stay in mem_dump_reader.
// - All state registers use an asynchronous active-low reset; no other asynchronous logic.
// TESTING
// 1. Image word k = 32'hA0B0C0D0 + k, i_tx_ready=1, pulse i_start -> 128 bytes
//    A0,B0,C0,D0,A0,B0,C0,D1,... last word bytes A0,B0,C0,EF; o_done pulses once.
//    First byte is valid 2 cycles after i_start.
// 2. i_tx_ready low for 5 cycles mid-word (word 3) -> o_tx_data and o_tx_valid
//    stay stable; no byte is dropped or duplicated; the sequence is still correct.
// 3. Change i_bus_debug word 0 from 32'h11223344 to 32'hFFFFFFFF during SEND of word 0
//    -> bytes 11,22,33,44 are still sent.
// 4. Pulse i_start again at byte 10 -> ignored; total remains 128 bytes and one o_done.
// 5. i_flush at word 7 byte 2 -> IDLE next cycle, o_tx_valid=0, o_addr=0, no o_done;
//    a following i_start restarts from word 0 byte 0.
// 6. i_reset=0 asserted asynchronously mid-SEND -> all outputs 0 without waiting for
//    an edge; after release the block idles until i_start.

Source files
------------

// File: rtl/mem_dump_reader_pkg.sv
// Shared constants and FSM encoding for the data-memory dump reader.
// Default bus geometry matches the MIPS data memory debug port.
package mem_dump_reader_pkg;

    localparam int IO_BUS_SIZE_DEF   = 32;
    localparam int MEM_ADDR_SIZE_DEF = 5;
    localparam int BYTE_SIZE_DEF     = 8;

    localparam int BYTES_PER_WORD = IO_BUS_SIZE_DEF / BYTE_SIZE_DEF;

    // A one-byte word still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BYTE_CNT_W = cnt_width(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_dump_reader_word_serializer.sv
// Word load/shift register with byte counter; emits the MSB byte first.
// Clear has priority so an aborted dump restarts at byte 0.
module mem_dump_reader_word_serializer
    import mem_dump_reader_pkg::*;
#(
    parameter int WORD_W = IO_BUS_SIZE_DEF,
    parameter int BYTE_W = BYTE_SIZE_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_word,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_last
);

    localparam int BPW   = WORD_W / BYTE_W;
    localparam int CNT_W = cnt_width(BPW);

    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_clear) begin
            cnt_q   <= '0;
        end else if (i_load) begin
            shift_q <= i_word;
            cnt_q   <= '0;
        end else if (i_shift) begin
            shift_q <= shift_q << BYTE_W;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign o_byte = shift_q[WORD_W-1 -: BYTE_W];
    assign o_last = (cnt_q == CNT_W'(BPW - 1));

endmodule

// File: rtl/mem_dump_reader.sv
// Streams the whole data memory image, big-endian, to the debug UART TX.
// FSM and word address live here; byte sequencing is in the serializer.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int IO_BUS_SIZE   = IO_BUS_SIZE_DEF,
    parameter int MEM_ADDR_SIZE = MEM_ADDR_SIZE_DEF,
    parameter int BYTE_SIZE     = BYTE_SIZE_DEF
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic                                     i_start,
    input  logic                                     i_flush,
    input  logic [2**MEM_ADDR_SIZE*IO_BUS_SIZE-1:0]  i_bus_debug,
    input  logic                                     i_tx_ready,
    output logic [BYTE_SIZE-1:0]                     o_tx_data,
    output logic                                     o_tx_valid,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic [MEM_ADDR_SIZE-1:0]                 o_addr
);

    localparam int WORDS = 2**MEM_ADDR_SIZE;
    localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR =
        MEM_ADDR_SIZE'(WORDS - 1);

    state_t                   state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
    logic                     ser_load, ser_shift, ser_clear;
    logic                     ser_last;
    logic [BYTE_SIZE-1:0]     ser_byte;
    logic [IO_BUS_SIZE-1:0]   cur_word;
    logic                     hs;

    assign cur_word = i_bus_debug[addr_q*IO_BUS_SIZE +: IO_BUS_SIZE];
    assign hs       = o_tx_valid & i_tx_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        ser_clear = 1'b0;
        if (i_flush) begin
            state_d   = ST_IDLE;
            addr_d    = '0;
            ser_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_LOAD;
                        addr_d  = '0;
                    end
                end
                ST_LOAD: begin
                    ser_load = 1'b1;
                    state_d  = ST_SEND;
                end
                ST_SEND: begin
                    if (hs) begin
                        if (!ser_last) begin
                            ser_shift = 1'b1;
                        end else if (addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    mem_dump_reader_word_serializer #(
        .WORD_W (IO_BUS_SIZE),
        .BYTE_W (BYTE_SIZE)
    ) u_word_serializer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (ser_clear),
        .i_load  (ser_load),
        .i_shift (ser_shift),
        .i_word  (cur_word),
        .o_byte  (ser_byte),
        .o_last  (ser_last)
    );

    assign o_tx_valid = (state_q == ST_SEND);
    assign o_tx_data  = o_tx_valid ? ser_byte : '0;
    assign o_busy     = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign o_done     = (state_q == ST_DONE);
    assign o_addr     = addr_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: stimulus queues expected bytes,
// a negedge monitor pops and compares on every accepted byte.
`timescale 1ns/1ps
module tb_mem_dump_reader;

    localparam int W = 32;
    localparam int A = 5;
    localparam int B = 8;
    localparam int N = 2**A;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           flush = 1'b0;
    logic           tx_ready = 1'b1;
    logic [N*W-1:0] bus = '0;
    logic [B-1:0]   tx_data;
    logic           tx_valid;
    logic           busy;
    logic           done;
    logic [A-1:0]   addr;

    mem_dump_reader #(
        .IO_BUS_SIZE   (W),
        .MEM_ADDR_SIZE (A),
        .BYTE_SIZE     (B)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_flush     (flush),
        .i_bus_debug (bus),
        .i_tx_ready  (tx_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_addr      (addr)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passes = 0;
    int         nbytes = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Monitor: a byte counts as accepted when valid & ready are seen here.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", {31'd0, tx_valid}, 32'd1);
                chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_byte: got %h want none", tx_data);
                end else begin
                    chk($sformatf("byte%0d", nbytes), {24'd0, tx_data},
                        {24'd0, exp_q.pop_front()});
                end
                nbytes++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_image(input logic [31:0] base);
        for (int k = 0; k < N; k++) bus[k*W +: W] = base + k;
    endtask

    task automatic push_image();
        logic [31:0] w;
        for (int k = 0; k < N; k++) begin
            w = bus[k*W +: W];
            for (int j = 3; j >= 0; j--) exp_q.push_back(w[j*8 +: 8]);
        end
    endtask

    task automatic start_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int c = 0;
        while (nbytes < n && c < 2000) begin
            tick();
            c++;
        end
        chk("wait_bytes", {31'd0, nbytes >= n}, 32'd1);
    endtask

    task automatic wait_done(input int target);
        int c = 0;
        while (done_cnt < target && c < 2000) begin
            tick();
            c++;
        end
        chk("done_seen", {31'd0, done_cnt >= target}, 32'd1);
        repeat (3) tick();
        chk("done_once", done_cnt, target);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_addr", {27'd0, addr}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("byte_total", nbytes, 32'd128);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10;
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {27'd0, addr}, 32'd0);
        #3 rst_n = 1'b1;
        repeat (3) tick();

        // Full dump at full rate, with first-byte latency.
        set_image(32'hA0B0C0D0);
        nbytes = 0;
        push_image();
        start_dump();
        chk("lat_load_busy", {31'd0, busy}, 32'd1);
        chk("lat_load_valid", {31'd0, tx_valid}, 32'd0);
        tick();
        chk("lat_first_valid", {31'd0, tx_valid}, 32'd1);
        chk("lat_first_data", {24'd0, tx_data}, 32'hA0);
        wait_done(1);

        // Back-pressure for 5 cycles at word 3 byte 2.
        nbytes = 0;
        push_image();
        start_dump();
        wait_bytes(14);
        tx_ready = 1'b0;
        repeat (5) tick();
        tx_ready = 1'b1;
        wait_done(2);

        // Image change during SEND and an ignored restart request.
        bus[0 +: W] = 32'h11223344;
        nbytes = 0;
        push_image();
        start_dump();
        wait_bytes(1);
        bus[0 +: W] = 32'hFFFFFFFF;
        wait_bytes(10);
        start_dump();
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(3);

        // Flush at word 7 byte 2, then a clean restart.
        set_image(32'hA0B0C0D0);
        nbytes = 0;
        push_image();
        start_dump();
        wait_bytes(30);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, tx_valid}, 32'd0);
        chk("flush_addr", {27'd0, addr}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) tick();
        chk("flush_no_done", done_cnt, 32'd3);
        nbytes = 0;
        push_image();
        start_dump();
        wait_done(4);

        // Asynchronous reset in the middle of SEND.
        nbytes = 0;
        push_image();
        start_dump();
        wait_bytes(20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, tx_valid}, 32'd0);
        chk("arst_data", {24'd0, tx_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_addr", {27'd0, addr}, 32'd0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("post_rst_done_cnt", done_cnt, 32'd4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
